iomem_arbiter: RTL and testbench

- Two-master arbiter sharing the single PicoSoC peripheral bus (iomem_*) between the CPU and a second bus master, e.g. a USB DMA engine.
- Masters and slave use the picorv32 native memory handshake: valid held until a one-cycle ready.
- Round-robin grant, one outstanding transaction, watchdog timeout that completes hung transfers with a fixed read value and a sticky error flag.
- Sits between picosoc's iomem port and the peripheral decode/register logic in the top level.

---
 rtl/iomem_arbiter.sv | 100 ++++++++++
 tb/tb_iomem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for the PicoSoC iomem bus.
// One outstanding transfer, watchdog completes hung transfers.
module iomem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        grant,
    output logic        timeout_err,
    input  logic        timeout_clr
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ?
                                        CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          to_hit;
    logic          done;

    assign busy   = (state == BUSY);
    // s_ready has priority over the watchdog in the same cycle
    assign to_hit = TO_EN && busy && !s_ready && (cnt == TO_LAST);
    assign done   = busy && (s_ready || to_hit);

    assign s_valid = busy;
    assign s_wstrb = grant ? m1_wstrb : m0_wstrb;
    assign s_addr  = grant ? m1_addr  : m0_addr;
    assign s_wdata = grant ? m1_wdata : m0_wdata;

    assign m0_ready = done && !grant;
    assign m1_ready = done &&  grant;
    assign m0_rdata = (to_hit && !grant) ? TIMEOUT_RDATA : s_rdata;
    assign m1_rdata = (to_hit &&  grant) ? TIMEOUT_RDATA : s_rdata;

    // Arbitration FSM: pick a winner in IDLE, hold it until completion
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= 1'b1;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        state <= BUSY;
                        cnt   <= '0;
                        if (m0_valid && m1_valid)
                            grant <= ~grant;
                        else
                            grant <= m1_valid;
                    end
                end
                BUSY: begin
                    if (done)
                        state <= IDLE;
                    else if (TO_EN)
                        cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky timeout flag; a new timeout beats a clear
    always_ff @(posedge clk) begin
        if (reset)
            timeout_err <= 1'b0;
        else if (to_hit)
            timeout_err <= 1'b1;
        else if (timeout_clr)
            timeout_err <= 1'b0;
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed, table-driven bench for iomem_arbiter.
// Each vector is one clock cycle of inputs and expected outputs.
module tb_iomem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_ready;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_valid, m1_ready;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        grant, timeout_err, timeout_clr;

    localparam logic [31:0] A0 = 32'h0300_0000;
    localparam logic [31:0] D0 = 32'h0000_00A5;
    localparam logic [31:0] A1 = 32'h0300_0010;
    localparam logic [31:0] D1 = 32'h0BAD_F00D;
    localparam logic [31:0] TO = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    iomem_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err),
        .timeout_clr(timeout_clr)
    );

    typedef struct packed {
        logic        rst, m0v, m1v, sr;
        logic [31:0] srd;
        logic        clr;
        logic        sv, r0, r1, g, err;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   passes = 0;
    int   row    = 0;

    function automatic vec_t V(
        input logic rst, m0v, m1v, sr, input logic [31:0] srd,
        input logic clr, input logic sv, r0, r1, g, err,
        input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.m0v = m0v; v.m1v = m1v; v.sr = sr;
        v.srd = srd; v.clr = clr; v.sv = sv; v.r0 = r0;
        v.r1 = r1; v.g = g; v.err = err; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s row %0d: got %h expected %h",
                     nm, row, act, exp);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset       = v.rst;
        m0_valid    = v.m0v;
        m1_valid    = v.m1v;
        s_ready     = v.sr;
        s_rdata     = v.srd;
        timeout_clr = v.clr;
        #1;
        chk("s_valid", {31'd0, s_valid}, {31'd0, v.sv});
        chk("m0_ready", {31'd0, m0_ready}, {31'd0, v.r0});
        chk("m1_ready", {31'd0, m1_ready}, {31'd0, v.r1});
        chk("grant", {31'd0, grant}, {31'd0, v.g});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, v.err});
        if (v.r0) chk("m0_rdata", m0_rdata, v.rd);
        if (v.r1) chk("m1_rdata", m1_rdata, v.rd);
        if (v.sv) begin
            chk("s_addr", s_addr, v.g ? A1 : A0);
            chk("s_wdata", s_wdata, v.g ? D1 : D0);
            chk("s_wstrb", {28'd0, s_wstrb},
                {28'd0, (v.g ? 4'h0 : 4'hF)});
        end
        row++;
    endtask

    task automatic busy_rows(input int n, input logic m0v, m1v,
                             input logic g, err);
        for (int i = 0; i < n; i++)
            apply(V(0, m0v, m1v, 0, 32'h5555_5555, 0,
                    1, 0, 0, g, err, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1; m0_valid = 0; m1_valid = 0; s_ready = 0;
        s_rdata = 0; timeout_clr = 0;
        m0_addr = A0; m0_wdata = D0; m0_wstrb = 4'hF;
        m1_addr = A1; m1_wdata = D1; m1_wstrb = 4'h0;
        repeat (2) @(posedge clk);

        // reset state
        tbl.push_back(V(1,0,0,0,0,0, 0,0,0,1,0,0));
        // m0 write, slave readies one cycle after s_valid
        tbl.push_back(V(0,1,0,0,0,0, 0,0,0,1,0,0));
        tbl.push_back(V(0,1,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(V(0,1,0,1,0,0, 1,1,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0, 0,0,0,0,0,0));
        // both read from reset: m0 first, then m1
        tbl.push_back(V(1,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,1,1,0,0,0, 0,0,0,1,0,0));
        tbl.push_back(V(0,1,1,1,32'h1111_1111,0,
                        1,1,0,0,0,32'h1111_1111));
        tbl.push_back(V(0,0,1,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0,1,1,32'h2222_2222,0,
                        1,0,1,1,0,32'h2222_2222));
        tbl.push_back(V(0,0,0,0,0,0, 0,0,0,1,0,0));
        // six back-to-back transfers with both held
        for (int k = 0; k < 6; k++) begin
            logic odd;
            odd = logic'(k % 2);
            tbl.push_back(V(0,1,1,1,32'h100 + k,0,
                            0,0,0,~odd,0,0));
            tbl.push_back(V(0,1,1,1,32'h100 + k,0,
                            1,~odd,odd,odd,0,32'h100 + k));
        end
        tbl.push_back(V(0,0,0,0,0,0, 0,0,0,1,0,0));

        foreach (tbl[i]) apply(tbl[i]);

        // m1 timeout on the 8th BUSY cycle
        apply(V(0,0,1,0,0,0, 0,0,0,1,0,0));
        busy_rows(7, 0, 1, 1, 0);
        apply(V(0,0,1,0,32'h5555_5555,0, 1,0,1,1,0,TO));
        apply(V(0,0,0,0,0,0, 0,0,0,1,1,0));
        // good transfer keeps the sticky flag
        apply(V(0,1,0,0,0,0, 0,0,0,1,1,0));
        apply(V(0,1,0,1,32'hA,0, 1,1,0,0,1,32'hA));
        apply(V(0,0,0,0,0,0, 0,0,0,0,1,0));
        // reset in 3rd BUSY cycle, then re-grant held m0
        apply(V(0,1,0,0,0,0, 0,0,0,0,1,0));
        busy_rows(2, 1, 0, 0, 1);
        apply(V(1,1,0,0,0,0, 1,0,0,0,1,0));
        apply(V(0,1,0,0,0,0, 0,0,0,1,0,0));
        apply(V(0,1,0,1,32'h77,0, 1,1,0,0,0,32'h77));
        apply(V(0,0,0,0,0,0, 0,0,0,0,0,0));
        // timeout coinciding with clear: flag stays set
        apply(V(0,1,0,0,0,0, 0,0,0,0,0,0));
        busy_rows(7, 1, 0, 0, 0);
        apply(V(0,1,0,0,32'h5555_5555,1, 1,1,0,0,0,TO));
        apply(V(0,0,0,0,0,0, 0,0,0,0,1,0));
        apply(V(0,0,0,0,0,1, 0,0,0,0,1,0));
        apply(V(0,0,0,0,0,0, 0,0,0,0,0,0));
        // s_ready exactly on the 8th BUSY cycle wins
        apply(V(0,1,0,0,0,0, 0,0,0,0,0,0));
        busy_rows(7, 1, 0, 0, 0);
        apply(V(0,1,0,1,32'h1234_5678,0,
                1,1,0,0,0,32'h1234_5678));
        apply(V(0,0,0,0,0,0, 0,0,0,0,0,0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
